// File: rtl/mem_port_mux_pkg.sv
// mem_port_mux_pkg: FSM state encoding and timeout response constant for mem_port_mux
package mem_port_mux_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_port_mux.sv
// mem_port_mux: muxes arbitrated request channels onto one memory bus, routes the response back
// Optional response watchdog enabled by defining MEM_MUX_TIMEOUT_EN.
module mem_port_mux
  import mem_port_mux_pkg::*;
#(
  parameter int PORTS          = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IW            = PORTS > 1 ? $clog2(PORTS) : 1,
  localparam int SW            = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [PORTS-1:0]         arb_request,
  input  logic [PORTS-1:0]         arb_grant,
  input  logic                     arb_grant_valid,
  input  logic [IW-1:0]            arb_grant_idx,
  output logic [PORTS-1:0]         arb_ack,
  input  logic [PORTS-1:0]         s_req_valid,
  output logic [PORTS-1:0]         s_req_ready,
  input  logic [PORTS*ADDR_W-1:0]  s_req_addr,
  input  logic [PORTS-1:0]         s_req_wen,
  input  logic [PORTS*DATA_W-1:0]  s_req_wdata,
  input  logic [PORTS*SW-1:0]      s_req_wstrb,
  output logic [PORTS-1:0]         s_resp_valid,
  input  logic [PORTS-1:0]         s_resp_ready,
  output logic [DATA_W-1:0]        s_resp_rdata,
  output logic                     s_resp_err,
  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [ADDR_W-1:0]        m_req_addr,
  output logic                     m_req_wen,
  output logic [DATA_W-1:0]        m_req_wdata,
  output logic [SW-1:0]            m_req_wstrb,
  input  logic                     m_resp_valid,
  output logic                     m_resp_ready,
  input  logic [DATA_W-1:0]        m_resp_rdata
);
  state_t           state;
  logic [IW-1:0]    idx;
  logic [PORTS-1:0] sel;
  logic             accept, timed_out, resp_hs;
  assign sel = {{(PORTS-1){1'b0}}, 1'b1} << idx;
  always_comb begin
    accept       = !rst && state == IDLE && arb_grant_valid && s_req_valid[arb_grant_idx];
    arb_request  = s_req_valid;
    s_req_ready  = accept ? arb_grant : '0;
    m_req_valid  = state == REQ;
    m_resp_ready = state == RESP && !timed_out && s_resp_ready[idx];
    s_resp_valid = (state == RESP && (timed_out || m_resp_valid)) ? sel : '0;
    s_resp_rdata = state != RESP ? '0 : timed_out ? DATA_W'(TIMEOUT_RDATA) : m_resp_rdata;
    s_resp_err   = state == RESP && timed_out;
    arb_ack      = state == DONE ? sel : '0;
    resp_hs      = |(s_resp_valid & s_resp_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      m_req_addr  <= '0;
      m_req_wen   <= 1'b0;
      m_req_wdata <= '0;
      m_req_wstrb <= '0;
    end else if (accept) begin
      state       <= REQ;
      idx         <= arb_grant_idx;
      m_req_addr  <= s_req_addr[arb_grant_idx*ADDR_W +: ADDR_W];
      m_req_wen   <= s_req_wen[arb_grant_idx];
      m_req_wdata <= s_req_wdata[arb_grant_idx*DATA_W +: DATA_W];
      m_req_wstrb <= s_req_wstrb[arb_grant_idx*SW +: SW];
    end else if (state == REQ && m_req_ready) begin
      state <= RESP;
    end else if (state == RESP && resp_hs) begin
      state <= DONE;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
`ifdef MEM_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timed_out = cnt == CW'(TIMEOUT_CYCLES);
  // cleared throughout REQ so it reads zero on the first RESP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (state == REQ) cnt <= '0;
    else if (state == RESP && !(m_resp_valid && m_resp_ready) && !timed_out) cnt <= cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif
endmodule
